// File: rtl/handshake_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin handshake arbiter.
package handshake_arb_pkg;

  localparam int unsigned DEFAULT_N     = 3;
  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned STAT_W        = 8;

  // Index width for an n-entry field, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/handshake_rr_arbiter_if.sv
// Request/result handshake bundle between requester lanes, arbiter and consumer.
interface handshake_rr_arbiter_if #(
  parameter int unsigned N     = handshake_arb_pkg::DEFAULT_N,
  parameter int unsigned WIDTH = handshake_arb_pkg::DEFAULT_WIDTH,
  parameter int unsigned IDX_W = handshake_arb_pkg::idx_w(N)
);

  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*WIDTH-1:0] req_in1;
  logic [N*WIDTH-1:0] req_in2;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_xor;
  logic               out_flag;
  logic [IDX_W-1:0]   out_src;

  // Requesters plus consumer side.
  modport master (
    output req_valid, req_in1, req_in2, out_ready,
    input  req_ready, out_valid, out_xor, out_flag, out_src
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_in1, req_in2, out_ready,
    output req_ready, out_valid, out_xor, out_flag, out_src
  );

endinterface

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid lane after 'last', wrapping.
module rr_pick
  import handshake_arb_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  int unsigned      cand;
  logic [IDX_W-1:0] cidx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    cidx      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last) + k) % N;
      cidx = IDX_W'(cand);
      if (!any && req[cidx]) begin
        grant[cidx] = 1'b1;
        grant_idx   = cidx;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter feeding one registered XOR/reduce result stage.
// Optional per-lane transfer counters enabled by HANDSHAKE_RR_ARBITER_STATS_EN.
module handshake_rr_arbiter
  import handshake_arb_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned IDX_W = idx_w(N)
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  handshake_rr_arbiter_if.slave bus
`ifdef HANDSHAKE_RR_ARBITER_STATS_EN
  ,
  output logic [N*STAT_W-1:0]   grant_count
`endif
);

  logic [IDX_W-1:0] last_grant_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_xor_q;
  logic             out_flag_q;
  logic [IDX_W-1:0] out_src_q;

  logic             load_en;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             any;
  logic             xfer;
  logic [WIDTH-1:0] win_in1;
  logic [WIDTH-1:0] win_in2;

  // Output stage can take a new result when empty or being drained this cycle.
  assign load_en = RESETN && (!out_valid_q || bus.out_ready);

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req       (bus.req_valid),
    .last      (last_grant_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign bus.req_ready = grant & {N{load_en}};
  assign xfer          = any && load_en;

  // One-hot AND-OR select of the winning operand pair.
  always_comb begin
    win_in1 = '0;
    win_in2 = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        win_in1 = bus.req_in1[i*WIDTH +: WIDTH];
        win_in2 = bus.req_in2[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      last_grant_q <= IDX_W'(N - 1);
      out_valid_q  <= 1'b0;
      out_xor_q    <= '0;
      out_flag_q   <= 1'b0;
      out_src_q    <= '0;
    end else if (xfer) begin
      last_grant_q <= grant_idx;
      out_valid_q  <= 1'b1;
      out_xor_q    <= win_in1 ^ win_in2;
      out_flag_q   <= (|win_in1) && (&win_in1);
      out_src_q    <= grant_idx;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_xor   = out_xor_q;
  assign bus.out_flag  = out_flag_q;
  assign bus.out_src   = out_src_q;

`ifdef HANDSHAKE_RR_ARBITER_STATS_EN
  for (genvar g = 0; g < N; g++) begin : gen_stats
    logic [STAT_W-1:0] cnt_q;

    always_ff @(posedge CLK) begin
      if (!RESETN) begin
        cnt_q <= '0;
      end else if (xfer && grant[g] && (cnt_q != {STAT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign grant_count[g*STAT_W +: STAT_W] = cnt_q;
  end
`endif

endmodule

// File: doc/handshake_rr_arbiter.md
Name: handshake_rr_arbiter

Overview:
- Round-robin arbiter sharing one reduce/XOR datapath among N ready/valid requesters.
- Each requester presents an operand pair (in1, in2).
- Winner's operands are computed and registered into a single-entry output stage with a ready/valid handshake toward the consumer.
- Sits between the handshake lane array and the shared XOR/OR-reduce/AND-reduce logic; it sequences all access to that datapath.

Parameters:
- N, 3, number of requester lanes (2..8)
- WIDTH, 4, operand width in bits
- IDX_W, $clog2(N) (min 1), width of source-index field

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESETN  input  1  synchronous active-low reset
- req_valid  input  N  per-lane request valid
- req_ready  output  N  per-lane accept; one-hot or zero
- req_in1  input  N*WIDTH  lane i operand 1 at bits [i*WIDTH +: WIDTH]
- req_in2  input  N*WIDTH  lane i operand 2, same packing
- out_valid  output  1  result valid
- out_ready  input  1  consumer accept
- out_xor  output  WIDTH  in1 ^ in2 of granted lane
- out_flag  output  1  (|in1) && (&in1) of granted lane
- out_src  output  IDX_W  index of granted lane

Behaviour:
- Interface (already decided): one clock CLK; reset RESETN is synchronous and active-low.
- Reset (RESETN low at a clock edge):
  - out_valid=0, out_xor=0, out_flag=0, out_src=0.
  - Round-robin pointer last_grant=N-1, so lane 0 has first priority.
  - req_ready=0 while RESETN is low.
- Load condition:
  - load_en = RESETN && (!out_valid || out_ready).
  - Output register accepts a new result when empty, or when full and being drained the same cycle.
- Arbitration (combinational):
  - Search req_valid starting at (last_grant+1) mod N, wrapping.
  - First asserted lane wins: grant one-hot, or zero if no valid.
  - req_ready = grant & {N{load_en}}.
  - req_ready never depends on out_valid of any other lane's pending data beyond load_en.
- Transfer on lane i: req_valid[i] && req_ready[i]. Next edge:
  - out_xor <= in1_i ^ in2_i
  - out_flag <= (|in1_i) && (&in1_i)
  - out_src <= i
  - out_valid <= 1
  - last_grant <= i
- Drain: out_valid && out_ready with no new transfer -> out_valid <= 0. Data fields hold their last values.
- Simultaneous drain and transfer: register reloads, out_valid stays 1. Sustained throughput is 1 result/cycle.
- Stall (out_valid && !out_ray):
  - All req_ready=0; output fields stable; last_grant unchanged.
- Latency: request accepted at edge k -> out_valid visible after edge k, i.e. 1 cycle.
- Fairness:
  - With all N lanes continuously valid and out_ready=1, grants cycle 0,1,..,N-1,0,...
  - No lane waits more than N-1 transfers.
- Pointer: advances only on an actual transfer; never on idle cycles.
- Requester protocol:
  - A lane may deassert req_valid before being granted; the arbiter holds no per-lane state.
  - Operands are sampled only at the transfer edge.
- Width rules: all operations are WIDTH bits, no extension. out_flag is 1-bit logical AND of the two reductions.
- Reset mid-operation: pending output is discarded and the pointer is restored to N-1. No partial transfer is completed.

Optional Feature:
- Macro: HANDSHAKE_RR_ARBITER_STATS_EN
- When defined:
  - Extra output grant_count, N*8 bits: per-lane 8-bit saturating counter of transfers, lane i at [i*8 +: 8].
  - Counter increments on that lane's transfer; saturates at 255.
  - Cleared by RESETN.
- When undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package handshake_arb_pkg:
  - Constants DEFAULT_N=3, DEFAULT_WIDTH=4, STAT_W=8.
  - Function idx_w(n) returning max(1,$clog2(n)).
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: req[N], last[IDX_W].
  - Outputs: grant[N] one-hot, grant_idx[IDX_W], any.
- Top module holds the output register, pointer and optional counters.

Test Plan:
- Reset with all req_valid=1: during RESETN=0, req_ready=0 and out_valid=0. First edge after release grants lane 0.
- Single lane 1, in1=4'hF, in2=4'h5, out_ready=1 -> next cycle out_valid=1, out_xor=4'hA, out_flag=1, out_src=1.
- Lanes 0,1,2 all valid, out_ready=1 for 6 cycles -> out_src sequence 0,1,2,0,1,2 with out_valid continuously 1.
- Backpressure:
  - Lane 2 in1=4'h3, in2=4'h0 accepted; then out_ready=0 for 3 cycles with lane 0 valid.
  - req_ready stays 0 and out_xor holds 4'h3, out_flag=0.
  - Raise out_ready -> lane 0 accepted the same cycle.
- Wrap/pointer:
  - Lane 2 granted last, then only lanes 0 and 2 valid -> lane 0 granted next.
  - Idle cycles with no valid leave the pointer unchanged.
- Stats build (HANDSHAKE_RR_ARBITER_STATS_EN): lane 0 alone valid for 300 transfers -> grant_count lane 0 = 255, other lanes 0. RESETN pulse clears all lanes to 0.
